// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports,
// one byte-enabled write port and a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never busy. All state updates on
// the falling edge of clk. reset is asynchronous and active-low.
// Optional feature: define REGFILE_BYPASS_EN to forward the in-flight
// write-back onto the read ports in the same cycle.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                rd_busy1,
    output logic                rd_busy2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                sb_set,
    input  logic [ADDR_W-1:0]   sb_addr,
    output logic                sb_ok
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // Issue acceptance: free, register 0, or the current producer retiring now.
    always_comb begin
        sb_ok = (sb_addr == '0) || !busy[sb_addr] || (wr_en && (wr_addr == sb_addr));
    end

    // Per-register set/clear decode for the scoreboard; register 0 never changes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        set_vec = '0;
        clr_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            set_vec[r] = sb_set && sb_ok && (sb_addr == ADDR_W'(r));
            clr_vec[r] = wr_en && (wr_addr == ADDR_W'(r));
        end
    end

    // Data storage: byte-lane merge of the write-back on the falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset on purpose -- reset must zero every
            // architectural register, so this cannot map to a plain RAM macro.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_live) begin
            // NOTE: sequential state uses non-blocking assignment only.
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    regs[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Busy bits: a new issue wins over the retiring write-back on the same register.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (set_vec[r]) begin
                    busy[r] <= 1'b1;
                end else if (clr_vec[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] wr_merged;

    // Merged write-back value: enabled lanes from wr_data, the rest from storage.
    always_comb begin
        wr_merged = regs[wr_addr];
        for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) begin
                wr_merged[k*8 +: 8] = wr_data[k*8 +: 8];
            end
        end
    end

    // Read ports with same-cycle forwarding of the write-back (suppressed in reset).
    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
        rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
        rd_busy1 = busy[rd_addr1];
        rd_busy2 = busy[rd_addr2];
        if (reset && wr_live && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_merged;
            rd_busy1 = sb_set && sb_ok && (sb_addr == rd_addr1);
        end
        if (reset && wr_live && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_merged;
            rd_busy2 = sb_set && sb_ok && (sb_addr == rd_addr2);
        end
    end
`else
    // Read ports show stored state only.
    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
        rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
        rd_busy1 = busy[rd_addr1];
        rd_busy2 = busy[rd_addr2];
    end
`endif

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file for the MIPS datapath; successor to the fixed 4x32 register file.
- Provides two combinational read ports and one write port with byte enables.
- Register 0 is hardwired to zero.
- Includes a per-register busy scoreboard. Issue logic marks a destination pending; the matching write-back clears it. Decode uses the busy flags to detect RAW/WAW hazards.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  asynchronous active-low reset.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data.
- rd_data2  output  DATA_W  read port 2 data.
- rd_busy1  output  1  busy flag of rd_addr1.
- rd_busy2  output  1  busy flag of rd_addr2.
- wr_en  input  1  write-back strobe.
- wr_addr  input  ADDR_W  write-back register address.
- wr_data  input  DATA_W  write-back data.
- wr_be  input  DATA_W/8  byte enables; bit k covers data[8k+7:8k].
- sb_set  input  1  request to mark sb_addr pending.
- sb_addr  input  ADDR_W  register to mark pending.
- sb_ok  output  1  the sb_set request would be accepted this cycle.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is reset.

Reset:
- reset low immediately clears all registers to 0 and all busy bits to 0, independent of clk.
- While reset is low, rd_data1/2 = 0, rd_busy1/2 = 0, sb_ok = 1.
- A write or sb_set coincident with reset assertion is discarded.

Read path:
- rd_dataN = reg[rd_addrN], combinational, zero latency.
- rd_busyN = busy[rd_addrN], combinational.
- Address 0 always reads 0 and is never busy.

Write path:
- On falling edge of clk with wr_en=1 and wr_addr != 0: each byte lane with wr_be[k]=1 takes wr_data; other lanes hold their value.
- wr_en with wr_addr=0 has no effect.
- wr_be=0 leaves the data unchanged, but the write still clears busy.

Scoreboard:
- Combinational sb_ok = (sb_addr==0) | ~busy[sb_addr] | (wr_en & wr_addr==sb_addr).
- On falling edge, for register r != 0:
  - set_r = sb_set & sb_ok & sb_addr==r.
  - clr_r = wr_en & wr_addr==r.
  - busy[r] <= set_r ? 1 : (clr_r ? 0 : busy[r]).
- Set wins over clear on the same register: a new producer is issued as the old one retires.
- sb_set while sb_ok=0 is rejected with no state change (WAW stall); issue logic must hold the request.
- sb_set with sb_addr=0 is accepted (sb_ok=1) and has no effect.
- A write to a non-busy register is legal and leaves busy=0.

Simultaneous events:
- Read and write of the same address in one cycle: the read returns the pre-edge value unless REGFILE_BYPASS_EN is defined.
- Write to A and set of B (A != B) in the same cycle are independent.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined:
  - If wr_en=1, wr_addr != 0 and rd_addrN==wr_addr, rd_dataN combinationally returns the merged value. Enabled lanes come from wr_data; other lanes come from reg.
  - rd_busyN is forced to 0 in that case unless sb_set & sb_ok & sb_addr==rd_addrN.
- Not defined:
  - Read ports show stored state only.
  - New data is visible after the falling edge that commits the write.

Test Plan:
1. Reset, then write 0xAAAAAAAA to r3 with wr_be=4'hF -> after the edge, rd_addr1=3 gives 0xAAAAAAAA and rd_addr2=0 gives 0.
2. r5=0x11223344; write 0xFFFFFFFF with wr_be=4'b0101 -> r5=0x11FF33FF.
3. sb_set r7 -> rd_busy1=1 for r7. A second sb_set r7 -> sb_ok=0 and busy stays 1. Write r7=0x5 -> busy=0 and data=5.
4. r9 busy; same cycle wr_en r9 and sb_set r9 -> sb_ok=1; after the edge r9 holds new data and busy=1.
5. Write 0xDEAD0000 to r0 and sb_set r0 -> r0 reads 0, rd_busy=0, sb_ok=1.
6. r4=0x1 and busy; assert reset low mid-cycle -> rd_data, busy and sb_ok go 0/0/1 immediately. With REGFILE_BYPASS_EN, after release, write r4=0x77 while reading r4 -> rd_data1=0x77 in the same cycle.
